// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared types and constants for the BNN inference controller.
//               Provides the controller state encoding, default parameter
//               values, a minimum-width clog2 helper, and the score/class
//               width types shared with the BNN core.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    // Controller states. The width is explicit so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int C_DEF_ROWS    = 8;
    localparam int C_DEF_COLS    = 8;
    localparam int C_DEF_CLASSES = 10;
    localparam int C_DEF_SCORE_W = 5;
    localparam int C_DEF_BNN_LAT = 1;

    // clog2 that never returns 0, so single-entry configurations still
    // get a legal 1-bit index or counter.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Default-width types shared with the BNN core.
    typedef logic [C_DEF_SCORE_W-1:0]           score_t;
    typedef logic [clog2_min1(C_DEF_CLASSES)-1:0] class_t;

endpackage
`default_nettype wire

// File: rtl/bnn_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : bnn_argmax_seq
// Description : Score buffer plus sequential argmax. On load the per-class
//               scores are captured; on start the scan visits one class per
//               cycle using a strict greater-than compare, so ties resolve
//               to the lowest index and all-zero scores yield class 0.
// Ports       : usb_clk, rst (async, active-high)
//               load         - capture scores_i into the score buffer
//               start        - arm the scan at index 0
//               abort        - drop an in-progress scan
//               scores_i     - flattened per-class scores
//               finish       - high during the last scan cycle
//               result_class - winner including the current compare
//               result_score - winning score including the current compare
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_argmax_seq
    import bnn_pkg::*;
#(
    parameter int CLASSES = C_DEF_CLASSES,
    parameter int SCORE_W = C_DEF_SCORE_W,
    parameter int CLS_W   = clog2_min1(CLASSES)
) (
    input  logic                       usb_clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CLASSES*SCORE_W-1:0] scores_i,
    output logic                       finish,
    output logic [CLS_W-1:0]           result_class,
    output logic [SCORE_W-1:0]         result_score
);

    logic [SCORE_W-1:0] r_buf [CLASSES];
    logic [CLS_W-1:0]   r_idx;
    logic [CLS_W-1:0]   r_arg;
    logic [SCORE_W-1:0] r_max;
    logic               r_active;

    logic [SCORE_W-1:0] w_cur;
    logic               w_take;
    logic               w_last;

    assign w_cur  = r_buf[r_idx];
    assign w_take = (w_cur > r_max);
    assign w_last = (r_idx == CLS_W'(CLASSES - 1));

    // The result folds in the current compare so the owner can latch the
    // final winner on the same edge that ends the scan.
    assign finish       = r_active && w_last;
    assign result_class = w_take ? r_idx : r_arg;
    assign result_score = w_take ? w_cur : r_max;

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CLASSES; c++) begin
                r_buf[c] <= '0;
            end
            r_idx    <= '0;
            r_arg    <= '0;
            r_max    <= '0;
            r_active <= 1'b0;
        end else begin
            if (load) begin
                for (int c = 0; c < CLASSES; c++) begin
                    r_buf[c] <= scores_i[c*SCORE_W +: SCORE_W];
                end
            end
            if (abort) begin
                r_active <= 1'b0;
            end else if (start) begin
                r_idx    <= '0;
                r_arg    <= '0;
                r_max    <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                if (w_take) begin
                    r_max <= w_cur;
                    r_arg <= r_idx;
                end
                if (w_last) begin
                    r_active <= 1'b0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bnn_inference_ctrl
// Description : Host-facing controller in front of the BNN core. Loads a
//               ROWS x COLS binary image row by row, tracks written rows,
//               launches the core under start/busy/done, waits BNN_LAT
//               cycles, captures the class scores and resolves the winner
//               with a sequential argmax.
// Ports       : usb_clk, rst (async, active-high)
//               wr_en/wr_addr/wr_data - row write port
//               clear    - synchronous abort, drops image and result
//               start    - inference request
//               busy     - high in RUN and SCAN
//               done     - high in DONE
//               err      - sticky protocol-violation flag
//               class_o  - winning class index
//               score_o  - winning score
//               image_o  - image to core, row r at [r*COLS +: COLS]
//               scores_i - scores from core, class c at [c*SCORE_W +: SCORE_W]
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_inference_ctrl
    import bnn_pkg::*;
#(
    parameter int ROWS    = C_DEF_ROWS,
    parameter int COLS    = C_DEF_COLS,
    parameter int CLASSES = C_DEF_CLASSES,
    parameter int SCORE_W = C_DEF_SCORE_W,
    parameter int BNN_LAT = C_DEF_BNN_LAT,
    parameter int ADDR_W  = clog2_min1(ROWS),
    parameter int CLS_W   = clog2_min1(CLASSES)
) (
    input  logic                       usb_clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [COLS-1:0]            wr_data,
    input  logic                       clear,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [CLS_W-1:0]           class_o,
    output logic [SCORE_W-1:0]         score_o,
    output logic [ROWS*COLS-1:0]       image_o,
    input  logic [CLASSES*SCORE_W-1:0] scores_i
);

    localparam int C_CNT_W = clog2_min1(BNN_LAT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ROWS*COLS-1:0]  r_image;
    logic [ROWS-1:0]       r_row_valid;
    logic [C_CNT_W-1:0]    r_cnt;
    logic                  r_err;
    logic [CLS_W-1:0]      r_class;
    logic [SCORE_W-1:0]    r_score;

    logic                  w_addr_ok;
    logic                  w_all_valid;
    logic                  w_run_last;
    logic                  w_wr_accept;
    logic                  w_start_accept;
    logic                  w_err_set;
    logic                  w_load;
    logic                  w_finish;
    logic [CLS_W-1:0]      w_res_class;
    logic [SCORE_W-1:0]    w_res_score;

    assign w_addr_ok   = (int'(wr_addr) < ROWS);
    assign w_all_valid = &r_row_valid;
    assign w_run_last  = (r_state == ST_RUN) && (r_cnt == C_CNT_W'(BNN_LAT - 1));

    assign busy    = (r_state == ST_RUN) || (r_state == ST_SCAN);
    assign done    = (r_state == ST_DONE);
    assign err     = r_err;
    assign class_o = r_class;
    assign score_o = r_score;
    assign image_o = r_image;

    // Scores are captured on the last RUN edge and the scan is armed on the
    // same edge, so SCAN starts the cycle after RUN ends.
    bnn_argmax_seq #(
        .CLASSES (CLASSES),
        .SCORE_W (SCORE_W),
        .CLS_W   (CLS_W)
    ) u_argmax (
        .usb_clk      (usb_clk),
        .rst          (rst),
        .load         (w_load),
        .start        (w_load),
        .abort        (clear),
        .scores_i     (scores_i),
        .finish       (w_finish),
        .result_class (w_res_class),
        .result_score (w_res_score)
    );

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and command decode. clear overrides everything, including
    // error reporting for any other input seen in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_accept    = 1'b0;
        w_start_accept = 1'b0;
        w_err_set      = 1'b0;
        w_load         = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (wr_en) begin
                        if (w_addr_ok) begin
                            w_wr_accept = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err_set = 1'b1;
                        end
                        // A start colliding with a write never launches.
                        if (start) begin
                            w_err_set = 1'b1;
                        end
                    end else if (start) begin
                        if (w_all_valid) begin
                            w_start_accept = 1'b1;
                            w_state_nxt    = ST_RUN;
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    w_err_set = wr_en;
                    if (w_run_last) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    w_err_set = wr_en;
                    if (w_finish) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            r_image     <= '0;
            r_row_valid <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_class     <= '0;
            r_score     <= '0;
        end else begin
            if (w_start_accept) begin
                r_cnt <= '0;
            end else if ((r_state == ST_RUN) && !w_run_last) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_start_accept) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end

            if (clear) begin
                r_image     <= '0;
                r_row_valid <= '0;
                r_class     <= '0;
                r_score     <= '0;
            end else begin
                for (int r = 0; r < ROWS; r++) begin
                    if (w_wr_accept && (int'(wr_addr) == r)) begin
                        r_image[r*COLS +: COLS] <= wr_data;
                        r_row_valid[r]          <= 1'b1;
                    end
                end
                // Result registers only move on entry to DONE, so partial
                // argmax values are never visible.
                if ((r_state == ST_SCAN) && w_finish) begin
                    r_class <= w_res_class;
                    r_score <= w_res_score;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bnn_inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_inference_ctrl
// Description : Scoreboard bench for bnn_inference_ctrl. Stimulus pushes the
//               expected class/score/done-cycle/busy-length per launch; a
//               monitor per DUT pops and compares when done rises.
//               DUT A: default geometry with a 4-bit row address so that
//               out-of-range rows can be driven. DUT B: 16x16, 4 classes,
//               BNN_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_inference_ctrl;

    localparam int A_SW = 5;
    localparam int A_CLS = 10;
    localparam int B_SW = 5;
    localparam int B_CLS = 4;

    typedef struct {
        int cls;
        int score;
        int due;
        int busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // DUT A signals
    logic        wr_en_a, clear_a, start_a;
    logic [3:0]  wr_addr_a;
    logic [7:0]  wr_data_a;
    logic        busy_a, done_a, err_a;
    logic [3:0]  class_a;
    logic [4:0]  score_a;
    logic [63:0] image_a;
    logic [49:0] scores_a;

    // DUT B signals
    logic         wr_en_b, clear_b, start_b;
    logic [3:0]   wr_addr_b;
    logic [15:0]  wr_data_b;
    logic         busy_b, done_b, err_b;
    logic [1:0]   class_b;
    logic [4:0]   score_b;
    logic [255:0] image_b;
    logic [19:0]  scores_b;

    bnn_inference_ctrl #(
        .ROWS(8), .COLS(8), .CLASSES(10), .SCORE_W(5), .BNN_LAT(1),
        .ADDR_W(4), .CLS_W(4)
    ) dut_a (
        .usb_clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .clear(clear_a), .start(start_a),
        .busy(busy_a), .done(done_a), .err(err_a), .class_o(class_a),
        .score_o(score_a), .image_o(image_a), .scores_i(scores_a)
    );

    bnn_inference_ctrl #(
        .ROWS(16), .COLS(16), .CLASSES(4), .SCORE_W(5), .BNN_LAT(3),
        .ADDR_W(4), .CLS_W(2)
    ) dut_b (
        .usb_clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .clear(clear_b), .start(start_b),
        .busy(busy_b), .done(done_b), .err(err_b), .class_o(class_b),
        .score_o(score_b), .image_o(image_b), .scores_i(scores_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin : mon_a
        logic pd;
        int   bc;
        exp_t e;
        pd = 1'b0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pd = 1'b0;
                bc = 0;
            end else begin
                if (busy_a) bc++;
                if (done_a && !pd) begin
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_done", 1, 0);
                    end else begin
                        e = q_a.pop_front();
                        chk("a_class", class_a, e.cls);
                        chk("a_score", score_a, e.score);
                        chk("a_done_cycle", cyc, e.due);
                        chk("a_busy_len", bc, e.busy);
                        chk("a_busy_low_in_done", busy_a, 0);
                    end
                    bc = 0;
                end
                pd = done_a;
            end
        end
    end

    initial begin : mon_b
        logic pd;
        int   bc;
        exp_t e;
        pd = 1'b0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pd = 1'b0;
                bc = 0;
            end else begin
                if (busy_b) bc++;
                if (done_b && !pd) begin
                    if (q_b.size() == 0) begin
                        chk("b_unexpected_done", 1, 0);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_class", class_b, e.cls);
                        chk("b_score", score_b, e.score);
                        chk("b_done_cycle", cyc, e.due);
                        chk("b_busy_len", bc, e.busy);
                    end
                    bc = 0;
                end
                pd = done_b;
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
        wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = data;
        @(negedge clk);
        wr_en_a = 1'b0;
    endtask

    task automatic clear_pulse_a();
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
    endtask

    task automatic set_scores_a(input int base, input int ca, input int va, input int cb, input int vb);
        for (int c = 0; c < A_CLS; c++) begin
            scores_a[c*A_SW +: A_SW] = A_SW'((c == ca) ? va : (c == cb) ? vb : base);
        end
    endtask

    // Launch sampled at edge k = cyc+1. Hand-computed for BNN_LAT=1 and
    // 10 classes: done is seen 12 cycles after the start cycle, i.e. after
    // edge k+11, with busy high for 11 cycles.
    task automatic launch_a(input bit expect_done, input int cls, input int sc);
        exp_t e;
        start_a = 1'b1;
        if (expect_done) begin
            e.cls = cls; e.score = sc; e.due = cyc + 1 + 11; e.busy = 11;
            q_a.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 60; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        chk("a_done_timeout", done_a, 1);
    endtask

    // BNN_LAT=3, 4 classes: done 8 cycles after start, busy for 7.
    task automatic launch_b(input int cls, input int sc);
        exp_t e;
        start_b = 1'b1;
        e.cls = cls; e.score = sc; e.due = cyc + 1 + 7; e.busy = 7;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_b();
        for (int i = 0; i < 60; i++) begin
            if (done_b) break;
            @(negedge clk);
        end
        chk("b_done_timeout", done_b, 1);
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        logic [63:0] img_exp;
        logic [15:0] rows_b [16];
        int sc_b [4];
        int best_c, best_s;

        rst = 1'b1;
        wr_en_a = 0; wr_addr_a = 0; wr_data_a = 0; clear_a = 0; start_a = 0; scores_a = '0;
        wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0; clear_b = 0; start_b = 0; scores_b = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_class", class_a, 0);
        chk("rst_score", score_a, 0);
        chk("rst_image", image_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic run, class 3 wins with 17
        for (int r = 0; r < 8; r++) write_a(4'(r), 8'hA5);
        chk("image_a5", image_a, {8{8'hA5}});
        set_scores_a(4, 3, 17, 3, 17);
        launch_a(1'b1, 3, 17);
        chk("busy_after_start", busy_a, 1);
        wait_done_a();

        // 2: missing row, then complete and launch; ties go to lowest index
        clear_pulse_a();
        chk("clear_image", image_a, 0);
        chk("clear_done", done_a, 0);
        chk("clear_class", class_a, 0);
        for (int r = 0; r < 7; r++) write_a(4'(r), 8'hA5);
        launch_a(1'b0, 0, 0);
        chk("missing_row_busy", busy_a, 0);
        chk("missing_row_err", err_a, 1);
        write_a(4'd7, 8'hA5);
        set_scores_a(5, 2, 31, 7, 31);
        launch_a(1'b1, 2, 31);
        chk("start_clears_err", err_a, 0);
        chk("busy_run2", busy_a, 1);
        wait_done_a();

        // 3: last index wins; write during SCAN is ignored
        set_scores_a(1, 9, 20, 0, 19);
        launch_a(1'b1, 9, 20);
        @(negedge clk);
        write_a(4'd4, 8'hFF);
        chk("scan_write_image", image_a, {8{8'hA5}});
        chk("scan_write_err", err_a, 1);
        wait_done_a();

        // 4: all-zero scores re-using the retained image
        set_scores_a(0, 0, 0, 0, 0);
        launch_a(1'b1, 0, 0);
        wait_done_a();
        chk("zero_err_cleared", err_a, 0);

        // 5: out-of-range row in DONE, then a valid write leaves DONE
        write_a(4'd9, 8'h00);
        chk("oob_err", err_a, 1);
        chk("oob_stays_done", done_a, 1);
        chk("oob_image", image_a, {8{8'hA5}});
        write_a(4'd4, 8'h3C);
        img_exp = {8{8'hA5}};
        img_exp[39:32] = 8'h3C;
        chk("done_write_image", image_a, img_exp);
        chk("done_write_drops_done", done_a, 0);

        // 6: reset mid-RUN, then a start with no rows flags err
        set_scores_a(6, 1, 9, 1, 9);
        launch_a(1'b0, 0, 0);
        chk("midrun_busy", busy_a, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy_a, 0);
        chk("midrun_rst_done", done_a, 0);
        chk("midrun_rst_image", image_a, 0);
        chk("midrun_rst_class", class_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch_a(1'b0, 0, 0);
        chk("post_rst_start_err", err_a, 1);
        chk("post_rst_start_busy", busy_a, 0);

        // 7: clear together with start in DONE
        for (int r = 0; r < 8; r++) write_a(4'(r), 8'h5A);
        set_scores_a(2, 1, 8, 1, 8);
        launch_a(1'b1, 1, 8);
        wait_done_a();
        clear_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0; start_a = 1'b0;
        chk("clr_start_done", done_a, 0);
        chk("clr_start_busy", busy_a, 0);
        chk("clr_start_image", image_a, 0);
        chk("clr_start_score", score_a, 0);
        chk("clr_start_err", err_a, 0);

        // 8: wide geometry against a reference argmax
        for (int r = 0; r < 16; r++) begin
            rows_b[r] = 16'($urandom);
            wr_en_b = 1'b1; wr_addr_b = 4'(r); wr_data_b = rows_b[r];
            @(negedge clk);
            wr_en_b = 1'b0;
        end
        chk("b_image_row5", image_b[5*16 +: 16], rows_b[5]);
        for (int run = 0; run < 4; run++) begin
            for (int c = 0; c < B_CLS; c++) begin
                sc_b[c] = (run == 3) ? 12 : int'($urandom_range(0, 31));
                scores_b[c*B_SW +: B_SW] = B_SW'(sc_b[c]);
            end
            best_c = 0;
            best_s = 0;
            for (int c = 0; c < B_CLS; c++) begin
                if (sc_b[c] > best_s) begin
                    best_s = sc_b[c];
                    best_c = c;
                end
            end
            launch_b(best_c, best_s);
            wait_done_b();
        end

        repeat (4) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
